// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone B4 pipelined arbiter.
package wshb_arb_pkg;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} arb_state_t;

    typedef logic mst_idx_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/wshb_arb_pend.sv
// Outstanding-transfer counter: +1 per accepted strobe, -1 per slave ack.
module wshb_arb_pend #(
    parameter int MAX_PEND = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic zero
);
    localparam int CW = $clog2(MAX_PEND) + 1;

    logic [CW-1:0] cnt;
    logic          dec_ok;

    // An ack with nothing outstanding is stray and must not underflow.
    assign dec_ok = dec && (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (inc && !dec_ok)
            cnt <= cnt + CW'(1);
        else if (!inc && dec_ok)
            cnt <= cnt - CW'(1);
    end

    assign full = (cnt == CW'(MAX_PEND));
    assign zero = (cnt == '0);

endmodule

// File: rtl/wshb_arbiter.sv
// Two-master Wishbone B4 pipelined arbiter for the shared SDRAM port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority to m0.
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_HOLD   = 64,
    parameter int MAX_PEND   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m0_cyc,
    input  logic                    m0_stb,
    input  logic                    m0_we,
    input  logic [ADDR_WIDTH-1:0]   m0_adr,
    input  logic [DATA_WIDTH-1:0]   m0_dat_ms,
    input  logic [DATA_WIDTH/8-1:0] m0_sel,
    output logic [DATA_WIDTH-1:0]   m0_dat_sm,
    output logic                    m0_ack,
    output logic                    m0_stall,
    input  logic                    m1_cyc,
    input  logic                    m1_stb,
    input  logic                    m1_we,
    input  logic [ADDR_WIDTH-1:0]   m1_adr,
    input  logic [DATA_WIDTH-1:0]   m1_dat_ms,
    input  logic [DATA_WIDTH/8-1:0] m1_sel,
    output logic [DATA_WIDTH-1:0]   m1_dat_sm,
    output logic                    m1_ack,
    output logic                    m1_stall,
    output logic                    s_cyc,
    output logic                    s_stb,
    output logic                    s_we,
    output logic [ADDR_WIDTH-1:0]   s_adr,
    output logic [DATA_WIDTH-1:0]   s_dat_ms,
    output logic [DATA_WIDTH/8-1:0] s_sel,
    input  logic [DATA_WIDTH-1:0]   s_dat_sm,
    input  logic                    s_ack,
    input  logic                    s_stall,
    output logic [1:0]              grant
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [1:0]                 cyc, stb, we, ack, stall;
    logic [1:0][ADDR_WIDTH-1:0] adr;
    logic [1:0][DATA_WIDTH-1:0] dat_ms, dat_sm;
    logic [1:0][SW-1:0]         sel;

    assign cyc    = {m1_cyc, m0_cyc};
    assign stb    = {m1_stb, m0_stb};
    assign we     = {m1_we, m0_we};
    assign adr    = {m1_adr, m0_adr};
    assign dat_ms = {m1_dat_ms, m0_dat_ms};
    assign sel    = {m1_sel, m0_sel};

    assign {m1_ack, m0_ack}     = ack;
    assign {m1_stall, m0_stall} = stall;
    assign m0_dat_sm            = dat_sm[0];
    assign m1_dat_sm            = dat_sm[1];

    arb_state_t    state, state_nxt;
    mst_idx_t      own, drain_m, rt;
    logic          own_vld, rt_vld, forced, tie_m1;
    logic          pend_full, pend_zero, accept;
    logic [HW-1:0] hold;

    assign own_vld = (state == OWN0) || (state == OWN1);
    assign own     = (state == OWN1);
    // Owner has used its quota and the other master is waiting.
    assign forced  = own_vld && (hold == HW'(MAX_HOLD)) && cyc[~own];
    assign accept  = s_stb && !s_stall;

`ifdef ARB_ROUND_ROBIN_EN
    mst_idx_t last;

    always_ff @(posedge clk) begin
        if (rst)
            last <= 1'b1;
        else if (state == IDLE && state_nxt != IDLE)
            last <= (state_nxt == OWN1);
    end

    assign tie_m1 = !last;
`else
    assign tie_m1 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = GRANT_NONE;
        s_cyc     = 1'b0;
        s_stb     = 1'b0;
        s_we      = 1'b0;
        s_adr     = '0;
        s_dat_ms  = '0;
        s_sel     = '0;
        case (state)
            IDLE: begin
                if (cyc[0] && cyc[1])
                    state_nxt = tie_m1 ? OWN1 : OWN0;
                else if (cyc[0])
                    state_nxt = OWN0;
                else if (cyc[1])
                    state_nxt = OWN1;
            end
            OWN0, OWN1: begin
                grant    = own ? GRANT_M1 : GRANT_M0;
                s_cyc    = 1'b1;
                // Strobe is held back whenever the owner is stalled by us, so the slave
                // never accepts a transfer the master thinks was refused.
                s_stb    = cyc[own] && stb[own] && !pend_full && !forced;
                s_we     = we[own];
                s_adr    = adr[own];
                s_dat_ms = dat_ms[own];
                s_sel    = sel[own];
                if (!cyc[own] || forced)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                s_cyc = !pend_zero;
                if (pend_zero)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !own_vld)
            hold <= '0;
        else if (accept && hold != HW'(MAX_HOLD))
            hold <= hold + HW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            drain_m <= 1'b0;
        else if (own_vld)
            drain_m <= own;
    end

    wshb_arb_pend #(.MAX_PEND(MAX_PEND)) u_pend (
        .clk  (clk),
        .rst  (rst),
        .inc  (accept),
        .dec  (s_ack),
        .full (pend_full),
        .zero (pend_zero)
    );

    // Acks follow the owner, or the previous owner while draining; a master that
    // already dropped cyc gets nothing and its leftover acks are absorbed.
    assign rt_vld = own_vld || (state == DRAIN);
    assign rt     = own_vld ? own : drain_m;

    for (genvar i = 0; i < 2; i++) begin : g_mst
        logic routed;
        assign routed    = rt_vld && (rt == 1'(i));
        assign ack[i]    = routed && cyc[i] && s_ack && !pend_zero;
        assign dat_sm[i] = routed ? s_dat_sm : '0;
        assign stall[i]  = !(own_vld && own == 1'(i)) || s_stall || pend_full || forced;
    end

endmodule
